// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage sequencer: owns the IF PC and the IF-R group register, arbitrates
// the next fetch address (backend flush > pre-decode redirect > sequential +12).
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_back,
    input  logic [31:0]           target_back,
    input  logic                  isJump,
    input  logic [31:0]           target_jump,
    input  logic                  valid_predict,
    input  logic [31:0]           target_predict,
    input  logic                  fifo_full,
    input  logic                  icache_miss,
    output logic                  fetch_req,
    output logic [31:0]           pc_if,
    output logic [2:0][31:0]      pc_ifr,
    output logic                  valid_inst_ifr,
    output logic                  fifo_we,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      redirect_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        REDIR = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      pc_if_reg, pc_if_next;
    logic [2:0][31:0] pc_ifr_reg;
    logic             valid_reg, valid_next;
    logic [CNT_W-1:0] redirect_cnt_reg, flush_cnt_reg;

    logic             accept;
    logic             pd_redir;
    logic [31:0]      pd_target;
    logic             flush_take;
    logic             capture;
    logic             redir_inc;
    logic             flush_inc;

    assign accept     = valid_reg & ~fifo_full;
    assign fifo_we    = accept & ~flush_back;
    assign pd_redir   = fifo_we & (isJump | valid_predict);
    assign pd_target  = isJump ? target_jump : target_predict;
    assign fetch_req  = (state_reg == RUN) & ~(valid_reg & fifo_full) & ~pd_redir & ~flush_back;
    // A flush arriving before the first fetch has nothing to cancel.
    assign flush_take = flush_back & (state_reg != BOOT);

    always_comb begin
        state_next = state_reg;
        pc_if_next = pc_if_reg;
        valid_next = valid_reg;
        capture    = 1'b0;
        redir_inc  = 1'b0;
        flush_inc  = 1'b0;

        if (flush_take) begin
            pc_if_next = {target_back[31:2], 2'b00};
            valid_next = 1'b0;
            state_next = REDIR;
            flush_inc  = 1'b1;
        end else if (pd_redir) begin
            pc_if_next = {pd_target[31:2], 2'b00};
            valid_next = 1'b0;
            state_next = RUN;
            redir_inc  = 1'b1;
        end else begin
            if (fetch_req && !icache_miss) begin
                capture    = 1'b1;
                valid_next = 1'b1;
                pc_if_next = pc_if_reg + 32'd12;
            end else if (accept) begin
                valid_next = 1'b0;
            end

            case (state_reg)
                BOOT:    state_next = RUN;
                RUN:     if (valid_reg && fifo_full) state_next = HOLD;
                HOLD:    if (!fifo_full) state_next = RUN;
                REDIR:   state_next = RUN;
                default: state_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= BOOT;
            pc_if_reg <= RESET_PC;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_if_reg <= pc_if_next;
            valid_reg <= valid_next;
        end
    end

    // Each IF-R slot captures its own offset from the fetch address.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pc_ifr_reg[gi] <= 32'd0;
                end else if (capture) begin
                    pc_ifr_reg[gi] <= pc_if_reg + 32'(4 * gi);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt_reg <= '0;
            flush_cnt_reg    <= '0;
        end else begin
            if (redir_inc && (redirect_cnt_reg != {CNT_W{1'b1}})) begin
                redirect_cnt_reg <= redirect_cnt_reg + 1'b1;
            end
            if (flush_inc && (flush_cnt_reg != {CNT_W{1'b1}})) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign pc_if          = pc_if_reg;
    assign pc_ifr         = pc_ifr_reg;
    assign valid_inst_ifr = valid_reg;
    assign state_o        = state_reg;
    assign redirect_cnt   = redirect_cnt_reg;
    assign flush_cnt      = flush_cnt_reg;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: boot, redirects, backpressure, flush priority,
// icache miss, wrap, counter saturation and asynchronous reset.
module tb_fetch_pc_ctrl;

    localparam int          CNT_W = 6;
    localparam logic [31:0] RPC   = 32'h1c000000;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush_back;
    logic [31:0]           target_back;
    logic                  isJump;
    logic [31:0]           target_jump;
    logic                  valid_predict;
    logic [31:0]           target_predict;
    logic                  fifo_full;
    logic                  icache_miss;
    logic                  fetch_req;
    logic [31:0]           pc_if;
    logic [2:0][31:0]      pc_ifr;
    logic                  valid_inst_ifr;
    logic                  fifo_we;
    logic [1:0]            state_o;
    logic [CNT_W-1:0]      redirect_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    fetch_pc_ctrl #(.RESET_PC(RPC), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_back     (flush_back),
        .target_back    (target_back),
        .isJump         (isJump),
        .target_jump    (target_jump),
        .valid_predict  (valid_predict),
        .target_predict (target_predict),
        .fifo_full      (fifo_full),
        .icache_miss    (icache_miss),
        .fetch_req      (fetch_req),
        .pc_if          (pc_if),
        .pc_ifr         (pc_ifr),
        .valid_inst_ifr (valid_inst_ifr),
        .fifo_we        (fifo_we),
        .state_o        (state_o),
        .redirect_cnt   (redirect_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge, then let inputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush_back = 1'b0; target_back = '0; isJump = 1'b0; target_jump = '0;
        valid_predict = 1'b0; target_predict = '0; fifo_full = 1'b0; icache_miss = 1'b0;
        #12;
        chk("rst_pc_if", pc_if, RPC);
        chk("rst_valid", 32'(valid_inst_ifr), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_fetch_req", 32'(fetch_req), 32'd0);
        chk("rst_fifo_we", 32'(fifo_we), 32'd0);
        chk("rst_pc_ifr0", pc_ifr[0], 32'd0);
        chk("rst_rcnt", 32'(redirect_cnt), 32'd0);

        // Boot
        tick(); rst = 1'b0; #1;
        chk("boot_c0_state", 32'(state_o), 32'd0);
        chk("boot_c0_fetch_req", 32'(fetch_req), 32'd0);
        tick();
        chk("boot_c1_state", 32'(state_o), 32'd1);
        chk("boot_c1_fetch_req", 32'(fetch_req), 32'd1);
        chk("boot_c1_pc_if", pc_if, 32'h1c000000);
        tick();
        chk("boot_c2_pc_if", pc_if, 32'h1c00000c);
        chk("boot_c2_ifr0", pc_ifr[0], 32'h1c000000);
        chk("boot_c2_ifr1", pc_ifr[1], 32'h1c000004);
        chk("boot_c2_ifr2", pc_ifr[2], 32'h1c000008);
        chk("boot_c2_valid", 32'(valid_inst_ifr), 32'd1);
        chk("boot_c2_fifo_we", 32'(fifo_we), 32'd1);

        // Pre-decode jump on the group at 0x1c00000c
        tick();
        chk("jmp_ifr0", pc_ifr[0], 32'h1c00000c);
        isJump = 1'b1; target_jump = 32'h1c000101; #1;
        chk("jmp_fifo_we", 32'(fifo_we), 32'd1);
        chk("jmp_fetch_req", 32'(fetch_req), 32'd0);
        tick(); isJump = 1'b0; #1;
        chk("jmp_pc_if", pc_if, 32'h1c000100);
        chk("jmp_valid", 32'(valid_inst_ifr), 32'd0);
        chk("jmp_rcnt", 32'(redirect_cnt), 32'd1);
        tick();
        chk("jmp_ifr0_next", pc_ifr[0], 32'h1c000100);
        chk("jmp_pc_if_next", pc_if, 32'h1c00010c);

        // Backpressure for 3 cycles
        fifo_full = 1'b1; #1;
        chk("bp0_fifo_we", 32'(fifo_we), 32'd0);
        chk("bp0_fetch_req", 32'(fetch_req), 32'd0);
        for (int i = 1; i < 3; i++) begin
            tick();
            chk("bp_state", 32'(state_o), 32'd2);
            chk("bp_fifo_we", 32'(fifo_we), 32'd0);
            chk("bp_fetch_req", 32'(fetch_req), 32'd0);
            chk("bp_ifr0", pc_ifr[0], 32'h1c000100);
            chk("bp_pc_if", pc_if, 32'h1c00010c);
            chk("bp_valid", 32'(valid_inst_ifr), 32'd1);
        end
        tick(); fifo_full = 1'b0; #1;
        chk("bp_rel_fifo_we", 32'(fifo_we), 32'd1);
        chk("bp_rel_fetch_req", 32'(fetch_req), 32'd0);
        tick();
        chk("bp_run_state", 32'(state_o), 32'd1);
        chk("bp_run_fetch_req", 32'(fetch_req), 32'd1);
        chk("bp_run_valid", 32'(valid_inst_ifr), 32'd0);
        tick();
        chk("bp_resume_ifr0", pc_ifr[0], 32'h1c00010c);

        // Flush beats a predicted-taken redirect in the same cycle
        flush_back = 1'b1; target_back = 32'h1c002002;
        valid_predict = 1'b1; target_predict = 32'h1c000500; #1;
        chk("fl_fifo_we", 32'(fifo_we), 32'd0);
        chk("fl_fetch_req", 32'(fetch_req), 32'd0);
        tick(); flush_back = 1'b0; valid_predict = 1'b0; #1;
        chk("fl_state", 32'(state_o), 32'd3);
        chk("fl_pc_if", pc_if, 32'h1c002000);
        chk("fl_fetch_req_redir", 32'(fetch_req), 32'd0);
        chk("fl_valid", 32'(valid_inst_ifr), 32'd0);
        chk("fl_fcnt", 32'(flush_cnt), 32'd1);
        chk("fl_rcnt", 32'(redirect_cnt), 32'd1);
        tick();
        chk("fl_run_state", 32'(state_o), 32'd1);
        chk("fl_run_fetch_req", 32'(fetch_req), 32'd1);
        tick();
        chk("fl_ifr0", pc_ifr[0], 32'h1c002000);

        // Predicted redirect to 0x1c000034, then icache miss at 0x1c000040
        valid_predict = 1'b1; target_predict = 32'h1c000035; #1;
        tick(); valid_predict = 1'b0; #1;
        chk("bpu_pc_if", pc_if, 32'h1c000034);
        chk("bpu_rcnt", 32'(redirect_cnt), 32'd2);
        tick();
        chk("mi_pre_pc_if", pc_if, 32'h1c000040);
        icache_miss = 1'b1; #1;
        chk("mi_a_fetch_req", 32'(fetch_req), 32'd1);
        chk("mi_a_fifo_we", 32'(fifo_we), 32'd1);
        tick();
        chk("mi_b_pc_if", pc_if, 32'h1c000040);
        chk("mi_b_valid", 32'(valid_inst_ifr), 32'd0);
        tick();
        chk("mi_c_pc_if", pc_if, 32'h1c000040);
        chk("mi_c_valid", 32'(valid_inst_ifr), 32'd0);
        icache_miss = 1'b0; #1;
        tick();
        chk("mi_d_valid", 32'(valid_inst_ifr), 32'd1);
        chk("mi_d_ifr0", pc_ifr[0], 32'h1c000040);
        chk("mi_d_ifr2", pc_ifr[2], 32'h1c000048);
        chk("mi_d_pc_if", pc_if, 32'h1c00004c);

        // 32-bit wrap of the sequential address
        flush_back = 1'b1; target_back = 32'hfffffff8; #1;
        tick(); flush_back = 1'b0; #1;
        chk("wr_fcnt", 32'(flush_cnt), 32'd2);
        tick();
        tick();
        chk("wr_pc_if", pc_if, 32'h00000004);
        chk("wr_ifr1", pc_ifr[1], 32'hfffffffc);
        chk("wr_ifr2", pc_ifr[2], 32'h00000000);

        // Saturate the redirect counter
        for (int i = 0; i < 70; i++) begin
            isJump = 1'b1; target_jump = 32'h1c000200; #1;
            tick(); isJump = 1'b0; #1;
            tick();
        end
        chk("sat_rcnt", 32'(redirect_cnt), 32'(2**CNT_W - 1));
        chk("sat_valid", 32'(valid_inst_ifr), 32'd1);

        // Asynchronous reset mid-RUN
        #2; rst = 1'b1; #1;
        chk("ar_pc_if", pc_if, RPC);
        chk("ar_valid", 32'(valid_inst_ifr), 32'd0);
        chk("ar_rcnt", 32'(redirect_cnt), 32'd0);
        chk("ar_fcnt", 32'(flush_cnt), 32'd0);
        chk("ar_state", 32'(state_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Fetch-stage sequencer. Owns the IF PC register and the IF-R pipeline register: `pc_ifr[2:0]` and `valid_inst_ifr`.
- Feeds the three-wide pre-decoder and consumes its `isJump`/`valid_predict` redirect outputs.
- Arbitrates the next fetch address with priority: backend flush, then pre-decode redirect, then sequential +12.
- Throttles fetch on inst_fifo backpressure and icache miss.

Parameters:
- `RESET_PC`, 32'h1c000000, first fetch address after reset.
- `CNT_W`, 16, width of the saturating redirect/flush counters.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `flush_back` in 1: backend redirect (mispredict/exception).
- `target_back` in 32: backend redirect address.
- `isJump` in 1: pre-decoder direct jump for the IF-R group.
- `target_jump` in 32: pre-decoder jump target.
- `valid_predict` in 1: pre-decoder BPU-taken indication.
- `target_predict` in 32: BPU target.
- `fifo_full` in 1: inst_fifo cannot accept this cycle.
- `icache_miss` in 1: fetch issued this cycle returns no data.
- `fetch_req` out 1: issue fetch of group at `pc_if`.
- `pc_if` out 32: current fetch address.
- `pc_ifr` out 32x3: IF-R slot addresses; `pc_ifr[i]` = base + 4i.
- `valid_inst_ifr` out 1: IF-R group valid.
- `fifo_we` out 1: IF-R group written to inst_fifo this cycle.
- `state_o` out 2: FSM state (BOOT=0, RUN=1, HOLD=2, REDIR=3).
- `redirect_cnt` out `CNT_W`: count of pre-decode redirects.
- `flush_cnt` out `CNT_W`: count of backend flushes.

Behaviour:
- Reset (async, immediate) values:
  - `pc_if` = `RESET_PC`; `pc_ifr` all 0; `valid_inst_ifr` = 0; state BOOT.
  - Both counters = 0; `fetch_req` = 0; `fifo_we` = 0.
  - Reset mid-operation discards any in-flight group.
- Combinational terms:
  - accept = `valid_inst_ifr` & !`fifo_full`.
  - `fifo_we` = accept & !`flush_back`.
  - pd_redir = `fifo_we` & (`isJump` | `valid_predict`).
  - pd_target = `isJump` ? `target_jump` : `target_predict`.
  - `fetch_req` = (state==RUN) & !(`valid_inst_ifr` & `fifo_full`) & !pd_redir & !`flush_back`.
- Fetch latency is 1 cycle. If `fetch_req` & !`icache_miss` at cycle t, then at t+1:
  - `valid_inst_ifr` = 1.
  - `pc_ifr` = {`pc_if`, `pc_if`+4, `pc_if`+8}.
  - `pc_if` = `pc_if`+12 (32-bit wrap).
- On `icache_miss` with `fetch_req`: `pc_if` holds, retry next cycle. IF-R becomes invalid if it was accepted or empty.
- IF-R hold: `valid_inst_ifr`=1 and `fifo_full`=1 with no flush → `pc_ifr` and `valid_inst_ifr` held unchanged.
- IF-R clear: when accepted with no new fetch capture → `valid_inst_ifr` <= 0.
- pd_redir (RUN or HOLD):
  - `pc_if` <= {pd_target[31:2], 2'b00}; `valid_inst_ifr` <= 0; state <= RUN.
  - One-cycle bubble; `redirect_cnt` +1, saturating at all-ones.
- `flush_back` (any state except BOOT, where it is ignored):
  - `pc_if` <= {`target_back`[31:2], 2'b00}; `valid_inst_ifr` <= 0; state <= REDIR.
  - `flush_cnt` +1, saturating.
  - Overrides pd_redir, stall and icache activity in the same cycle.
- FSM:
  - BOOT → RUN unconditionally on the first clock after reset release.
  - RUN → HOLD when `valid_inst_ifr` & `fifo_full` & !`flush_back`.
  - HOLD: `fetch_req`=0. HOLD → RUN on the cycle `fifo_full`=0; the group is written that cycle and fetch resumes the next cycle.
  - REDIR: `fetch_req`=0 (icache flush slot). REDIR → RUN next cycle. `flush_back` again in REDIR stays in REDIR and reloads `pc_if`.
- Target bits [1:0] are always forced to 0. Sequential +12 may cross any boundary, with no alignment restriction beyond 4 bytes.

Test Plan:
1. Boot:
   - Stimulus: release `rst`, `fifo_full`=0, no miss.
   - Response: cycle0 BOOT, `fetch_req`=0. Cycle1 `fetch_req`=1, `pc_if`=0x1c000000. Cycle2 `pc_if`=0x1c00000c, `pc_ifr`={0x1c000000, 0x1c000004, 0x1c000008}, `valid_inst_ifr`=1, `fifo_we`=1.
2. Pre-decode jump:
   - Stimulus: group at 0x1c00000c accepted with `isJump`=1, `target_jump`=0x1c000101.
   - Response: next cycle `pc_if`=0x1c000100, `valid_inst_ifr`=0, `redirect_cnt`=1. Following cycle `pc_ifr[0]`=0x1c000100.
3. Backpressure:
   - Stimulus: `fifo_full`=1 for 3 cycles with a valid group.
   - Response: state HOLD, `fifo_we`=0, `fetch_req`=0, `pc_ifr` and `pc_if` unchanged. On `fifo_full`=0, `fifo_we`=1 that cycle; RUN and `fetch_req`=1 next cycle.
4. Flush priority:
   - Stimulus: `flush_back`=1, `target_back`=0x1c002000, same cycle as `valid_predict`=1 on an accepted group.
   - Response: `fifo_we`=0, `pc_if`=0x1c002000, state REDIR for 1 cycle with `fetch_req`=0, then RUN. `flush_cnt`=1, `redirect_cnt` unchanged.
5. Icache miss:
   - Stimulus: `icache_miss`=1 for 2 cycles at `pc_if`=0x1c000040.
   - Response: `pc_if` held at 0x1c000040, `valid_inst_ifr`=0 after the accepted group drains. When the miss clears, the group at 0x1c000040 appears next cycle.
6. Saturation/reset:
   - Stimulus: force 0xFFFF pd redirects.
   - Response: `redirect_cnt` stays 0xFFFF. Asserting `rst` mid-RUN immediately gives `pc_if`=0x1c000000, `valid_inst_ifr`=0, both counters 0.
